// File: rtl/char_tile_renderer.sv
// rtl/char_tile_renderer.sv - 40x30 8x8 character tile renderer reading char RAM/ROM for VGA output
module char_tile_renderer #(
    parameter int          H_LAST   = 383,
    parameter int          V_LAST   = 263,
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        pxl_cen,
    input  logic [8:0]  hcnt,
    input  logic [8:0]  vcnt,
    input  logic        hb_in,
    input  logic        vb_in,
    output logic [12:0] chram_addr,
    input  logic [7:0]  chram_data,
    output logic [10:0] chrom_addr,
    input  logic [7:0]  chrom_data,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hb_out,
    output logic        vb_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CADDR,
        S_CWAIT,
        S_RADDR,
        S_RWAIT
    } state_t;

    localparam logic [8:0] H_WRAP = 9'(H_LAST - 7);
    localparam logic [8:0] V_END  = 9'(V_LAST);

    state_t      state_q, state_d;
    logic [12:0] chram_addr_q, chram_addr_d;
    logic [10:0] chrom_addr_q, chrom_addr_d;
    logic [7:0]  code_q, code_d;
    logic [2:0]  line_q, line_d;
    logic [7:0]  next_row_q, next_row_d;
    logic [7:0]  shifter_q, shifter_d;
    logic [23:0] rgb_q, rgb_d;
    logic        hb_q, hb_d;
    logic        vb_q, vb_d;

    logic        trigger;
    logic        wrap;
    logic [8:0]  next_v;
    logic [5:0]  tgt_col;
    logic [4:0]  tgt_row;
    logic [2:0]  tgt_line;

    // The last tile slot of a line prefetches column 0 of the following line.
    assign trigger  = pxl_cen && (hcnt[2:0] == 3'd0);
    assign wrap     = (hcnt == H_WRAP);
    assign next_v   = (vcnt == V_END) ? 9'd0 : vcnt + 9'd1;
    assign tgt_col  = wrap ? 6'd0 : hcnt[8:3] + 6'd1;
    assign tgt_row  = wrap ? next_v[7:3] : vcnt[7:3];
    assign tgt_line = wrap ? next_v[2:0] : vcnt[2:0];

    always_comb begin
        state_d      = state_q;
        chram_addr_d = chram_addr_q;
        chrom_addr_d = chrom_addr_q;
        code_d       = code_q;
        line_d       = line_q;
        next_row_d   = next_row_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    chram_addr_d = {2'b00, tgt_row, tgt_col};
                    line_d       = tgt_line;
                    state_d      = S_CADDR;
                end
            end
            S_CADDR: state_d = S_CWAIT;
            S_CWAIT: begin
                code_d       = chram_data;
                chrom_addr_d = {chram_data, line_q};
                state_d      = S_RADDR;
            end
            S_RADDR: state_d = S_RWAIT;
            S_RWAIT: begin
                next_row_d = chrom_data;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shifter_d = shifter_q;
        rgb_d     = rgb_q;
        hb_d      = hb_q;
        vb_d      = vb_q;
        if (pxl_cen) begin
            shifter_d = (hcnt[2:0] == 3'd7) ? next_row_q : {shifter_q[6:0], 1'b0};
            rgb_d     = (hb_in || vb_in) ? 24'd0 : (shifter_q[7] ? FG_COLOR : BG_COLOR);
            hb_d      = hb_in;
            vb_d      = vb_in;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            chram_addr_q <= '0;
            chrom_addr_q <= '0;
            code_q       <= '0;
            line_q       <= '0;
            next_row_q   <= '0;
            shifter_q    <= '0;
            rgb_q        <= '0;
            hb_q         <= 1'b1;
            vb_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            chram_addr_q <= chram_addr_d;
            chrom_addr_q <= chrom_addr_d;
            code_q       <= code_d;
            line_q       <= line_d;
            next_row_q   <= next_row_d;
            shifter_q    <= shifter_d;
            rgb_q        <= rgb_d;
            hb_q         <= hb_d;
            vb_q         <= vb_d;
        end
    end

    assign chram_addr = chram_addr_q;
    assign chrom_addr = chrom_addr_q;
    assign r          = rgb_q[23:16];
    assign g          = rgb_q[15:8];
    assign b          = rgb_q[7:0];
    assign hb_out     = hb_q;
    assign vb_out     = vb_q;

endmodule

// File: tb/tb_char_tile_renderer.sv
// tb/tb_char_tile_renderer.sv - directed self-checking bench for char_tile_renderer
module tb_char_tile_renderer;

    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000000;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        pxl_cen = 1'b0;
    logic [8:0]  hcnt    = '0;
    logic [8:0]  vcnt    = '0;
    logic        hb_in   = 1'b1;
    logic        vb_in   = 1'b1;
    logic [12:0] chram_addr;
    logic [7:0]  chram_data = '0;
    logic [10:0] chrom_addr;
    logic [7:0]  chrom_data = '0;
    logic [7:0]  r, g, b;
    logic        hb_out, vb_out;

    logic [7:0]  chram [0:8191];
    logic [7:0]  chrom [0:2047];
    logic [7:0]  exp_row [0:39];

    int total = 0;
    int bad   = 0;

    char_tile_renderer dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .pxl_cen    (pxl_cen),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .hb_in      (hb_in),
        .vb_in      (vb_in),
        .chram_addr (chram_addr),
        .chram_data (chram_data),
        .chrom_addr (chrom_addr),
        .chrom_data (chrom_data),
        .r          (r),
        .g          (g),
        .b          (b),
        .hb_out     (hb_out),
        .vb_out     (vb_out)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        chram_data <= chram[chram_addr];
        chrom_data <= chrom[chrom_addr];
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic pix(input int h, input int v, input logic hb, input logic vb, input int gap);
        hcnt    = h[8:0];
        vcnt    = v[8:0];
        hb_in   = hb;
        vb_in   = vb;
        pxl_cen = 1'b1;
        @(posedge clk_sys);
        #1;
        pxl_cen = 1'b0;
        repeat (gap) @(posedge clk_sys);
        if (gap > 0) #1;
    endtask

    task automatic test_reset;
        idle(3);
        total++; if ({r, g, b} !== 24'd0) begin bad++; $display("FAIL reset_rgb got=%h exp=%h", {r, g, b}, 24'd0); end
        total++; if (hb_out !== 1'b1) begin bad++; $display("FAIL reset_hb got=%b exp=1", hb_out); end
        total++; if (vb_out !== 1'b1) begin bad++; $display("FAIL reset_vb got=%b exp=1", vb_out); end
        total++; if (chram_addr !== 13'd0) begin bad++; $display("FAIL reset_chram_addr got=%h exp=0", chram_addr); end
        total++; if (chrom_addr !== 11'd0) begin bad++; $display("FAIL reset_chrom_addr got=%h exp=0", chrom_addr); end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_frame_start;
        logic [23:0] exp;
        chram[0] = 8'h41;
        for (int i = 0; i < 8; i++) chrom[11'h208 + i] = 8'hAA;
        for (int h = 376; h <= 383; h++) pix(h, 263, 1'b1, 1'b0, 1);
        for (int h = 0; h < 8; h++) begin
            pix(h, 0, 1'b0, 1'b0, 1);
            exp = (h % 2 == 0) ? FG : BG;
            total++;
            if ({r, g, b} !== exp) begin bad++; $display("FAIL frame_start_px%0d got=%h exp=%h", h, {r, g, b}, exp); end
        end
    endtask

    task automatic test_tile_addr;
        idle(6);
        chram[13'h085] = 8'h01;
        chrom[11'h00F] = 8'hFF;
        pix(32, 23, 1'b0, 1'b0, 0);
        total++; if (chram_addr !== 13'h085) begin bad++; $display("FAIL tile_chram_addr got=%h exp=085", chram_addr); end
        pix(33, 23, 1'b0, 1'b0, 0);
        pix(34, 23, 1'b0, 1'b0, 0);
        total++; if (chrom_addr !== 11'h00F) begin bad++; $display("FAIL tile_chrom_addr got=%h exp=00F", chrom_addr); end
        for (int h = 35; h < 40; h++) pix(h, 23, 1'b0, 1'b0, 0);
        for (int h = 40; h < 48; h++) begin
            pix(h, 23, 1'b0, 1'b0, 0);
            total++;
            if ({r, g, b} !== FG) begin bad++; $display("FAIL tile_px%0d got=%h exp=%h", h, {r, g, b}, FG); end
        end
    endtask

    task automatic test_wrap;
        idle(6);
        pix(376, 263, 1'b1, 1'b0, 0);
        total++; if (chram_addr !== 13'h000) begin bad++; $display("FAIL wrap_frame_chram_addr got=%h exp=000", chram_addr); end
        pix(377, 263, 1'b1, 1'b0, 0);
        pix(378, 263, 1'b1, 1'b0, 0);
        total++; if (chrom_addr !== 11'h208) begin bad++; $display("FAIL wrap_frame_chrom_addr got=%h exp=208", chrom_addr); end
        idle(4);
        pix(376, 23, 1'b1, 1'b0, 0);
        total++; if (chram_addr !== 13'h0C0) begin bad++; $display("FAIL wrap_line_chram_addr got=%h exp=0C0", chram_addr); end
        idle(6);
    endtask

    task automatic test_blank;
        chram[13'h086] = 8'h03;
        chrom[11'h01F] = 8'h96;
        for (int h = 32; h < 40; h++) pix(h, 23, 1'b0, 1'b0, 0);
        for (int h = 40; h < 48; h++) begin
            pix(h, 23, 1'b1, 1'b0, 0);
            if (h == 40) begin
                total++;
                if (chram_addr !== 13'h086) begin bad++; $display("FAIL blank_fetch_addr got=%h exp=086", chram_addr); end
            end
            total++;
            if ({r, g, b} !== 24'd0 || hb_out !== 1'b1) begin
                bad++; $display("FAIL blank_px%0d got rgb=%h hb=%b exp rgb=0 hb=1", h, {r, g, b}, hb_out);
            end
        end
        pix(48, 23, 1'b0, 1'b0, 0);
        total++;
        if ({r, g, b} !== FG || hb_out !== 1'b0) begin bad++; $display("FAIL unblank_px48 got rgb=%h hb=%b exp rgb=%h hb=0", {r, g, b}, hb_out, FG); end
        pix(49, 23, 1'b0, 1'b0, 0);
        total++;
        if ({r, g, b} !== BG) begin bad++; $display("FAIL unblank_px49 got=%h exp=%h", {r, g, b}, BG); end
        pix(50, 23, 1'b0, 1'b1, 0);
        total++;
        if ({r, g, b} !== 24'd0 || vb_out !== 1'b1) begin bad++; $display("FAIL vblank_px50 got rgb=%h vb=%b exp rgb=0 vb=1", {r, g, b}, vb_out); end
        idle(6);
    endtask

    task automatic test_back_to_back;
        logic [7:0] got;
        got = '0;
        for (int c = 0; c < 40; c++) begin
            exp_row[c]        = 8'(c * 37 + 11) ^ 8'hC3;
            chram[64 + c]     = 8'(c + 2);
            chrom[(c + 2) * 8] = exp_row[c];
        end
        for (int h = 376; h <= 383; h++) pix(h, 7, 1'b1, 1'b0, 0);
        for (int x = 0; x < 320; x++) begin
            pix(x, 8, 1'b0, 1'b0, 0);
            got[7 - (x % 8)] = ({r, g, b} === FG);
            if (x % 8 == 7) begin
                total++;
                if (got !== exp_row[x / 8]) begin bad++; $display("FAIL full_line_tile%0d got=%h exp=%h", x / 8, got, exp_row[x / 8]); end
            end
        end
        idle(6);
    endtask

    task automatic test_reset_mid;
        logic [7:0] got;
        got = '0;
        for (int h = 32; h <= 40; h++) pix(h, 23, 1'b0, 1'b0, 0);
        idle(1);
        reset = 1'b1;
        #1;
        total++; if ({r, g, b} !== 24'd0) begin bad++; $display("FAIL midreset_rgb got=%h exp=0", {r, g, b}); end
        total++; if (hb_out !== 1'b1 || vb_out !== 1'b1) begin bad++; $display("FAIL midreset_blank got hb=%b vb=%b exp 1 1", hb_out, vb_out); end
        total++; if (chram_addr !== 13'd0 || chrom_addr !== 11'd0) begin bad++; $display("FAIL midreset_addr got %h %h exp 0 0", chram_addr, chrom_addr); end
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        idle(2);
        pix(40, 23, 1'b0, 1'b0, 0);
        total++; if ({r, g, b} !== BG) begin bad++; $display("FAIL midreset_px40 got=%h exp=%h", {r, g, b}, BG); end
        for (int h = 41; h < 48; h++) pix(h, 23, 1'b0, 1'b0, 0);
        for (int h = 48; h < 56; h++) begin
            pix(h, 23, 1'b0, 1'b0, 0);
            got[55 - h] = ({r, g, b} === FG);
        end
        total++; if (got !== 8'h96) begin bad++; $display("FAIL midreset_row got=%h exp=96", got); end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) chram[i] = 8'h00;
        for (int i = 0; i < 2048; i++) chrom[i] = 8'h00;
        test_reset;
        test_frame_start;
        test_tile_addr;
        test_wrap;
        test_blank;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
